// File: rtl/onchip_mem_arbiter.sv
// Round-robin, bounded-hold arbiter giving two Avalon-MM masters shared use of a single-port on-chip RAM.
// Optional address range checking is enabled by defining ARB_BOUNDS_CHECK_EN.
module onchip_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 51200,
    parameter int MAX_HOLD  = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [ADDR_W-1:0]   m0_address_i,
    input  logic [DATA_W/8-1:0] m0_byteenable_i,
    input  logic                m0_read_i,
    input  logic                m0_write_i,
    input  logic [DATA_W-1:0]   m0_writedata_i,
    output logic                m0_waitrequest_o,
    output logic [DATA_W-1:0]   m0_readdata_o,
    output logic                m0_readdatavalid_o,
    input  logic [ADDR_W-1:0]   m1_address_i,
    input  logic [DATA_W/8-1:0] m1_byteenable_i,
    input  logic                m1_read_i,
    input  logic                m1_write_i,
    input  logic [DATA_W-1:0]   m1_writedata_i,
    output logic                m1_waitrequest_o,
    output logic [DATA_W-1:0]   m1_readdata_o,
    output logic                m1_readdatavalid_o,
    output logic [ADDR_W-1:0]   mem_address_o,
    output logic [DATA_W/8-1:0] mem_byteenable_o,
    output logic                mem_chipselect_o,
    output logic                mem_write_o,
    output logic [DATA_W-1:0]   mem_writedata_o,
    output logic                mem_clken_o,
    input  logic [DATA_W-1:0]   mem_readdata_i,
    output logic                err_oob_o
);
    localparam int BE_W = DATA_W / 8;
    localparam int HC_W = $clog2(MAX_HOLD + 1);
`ifdef ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic              rr_last_q, rr_last_d;
    logic              rd_pend_q, rd_owner_q, rd_zero_q;

    logic              req0, req1, gnt0, gnt1, gnt_any;
    logic [ADDR_W-1:0] acc_addr;
    logic [BE_W-1:0]   acc_be;
    logic [DATA_W-1:0] acc_wd, rd_data;
    logic              acc_wr, oob, rd_vld;

    assign req0 = m0_read_i | m0_write_i;
    assign req1 = m1_read_i | m1_write_i;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rr_last_d = rr_last_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state_q)
            OWN0: begin
                if (req0 && (!req1 || hold_q < HC_W'(MAX_HOLD))) gnt0 = 1'b1;
                else if (req1)                                   gnt1 = 1'b1;
            end
            OWN1: begin
                if (req1 && (!req0 || hold_q < HC_W'(MAX_HOLD))) gnt1 = 1'b1;
                else if (req0)                                   gnt0 = 1'b1;
            end
            default: begin
                // Tie from idle goes to whoever did not own the RAM last.
                if (req0 && req1) begin
                    gnt0 = rr_last_q;
                    gnt1 = !rr_last_q;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
        if (reset_i) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
        if (gnt0) begin
            state_d   = OWN0;
            rr_last_d = 1'b0;
            if (state_q != OWN0)                 hold_d = HC_W'(1);
            else if (hold_q < HC_W'(MAX_HOLD))   hold_d = hold_q + HC_W'(1);
        end else if (gnt1) begin
            state_d   = OWN1;
            rr_last_d = 1'b1;
            if (state_q != OWN1)                 hold_d = HC_W'(1);
            else if (hold_q < HC_W'(MAX_HOLD))   hold_d = hold_q + HC_W'(1);
        end else begin
            state_d = IDLE;
            hold_d  = '0;
        end
    end

    always_comb begin
        acc_addr = m0_address_i;
        acc_be   = m0_byteenable_i;
        acc_wd   = m0_writedata_i;
        acc_wr   = m0_write_i;
        if (gnt1) begin
            acc_addr = m1_address_i;
            acc_be   = m1_byteenable_i;
            acc_wd   = m1_writedata_i;
            acc_wr   = m1_write_i;
        end
    end

    assign gnt_any = gnt0 | gnt1;
    assign oob     = BOUNDS_EN && (32'(acc_addr) >= 32'(MEM_DEPTH));

    assign m0_waitrequest_o = !gnt0;
    assign m1_waitrequest_o = !gnt1;
    assign mem_address_o    = acc_addr;
    assign mem_byteenable_o = acc_wr ? acc_be : '1;
    assign mem_writedata_o  = acc_wd;
    assign mem_chipselect_o = gnt_any && !oob;
    assign mem_write_o      = gnt_any && acc_wr && !oob;
    assign mem_clken_o      = 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            rr_last_q  <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            rd_zero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            rr_last_q  <= rr_last_d;
            rd_pend_q  <= gnt_any && !acc_wr;
            rd_owner_q <= gnt1;
            rd_zero_q  <= oob;
        end
    end

    // A reset landing in the response cycle kills the pending valid immediately.
    assign rd_vld  = rd_pend_q && !reset_i;
    assign rd_data = rd_zero_q ? '0 : mem_readdata_i;

    assign m0_readdatavalid_o = rd_vld && !rd_owner_q;
    assign m1_readdatavalid_o = rd_vld && rd_owner_q;
    assign m0_readdata_o      = m0_readdatavalid_o ? rd_data : '0;
    assign m1_readdata_o      = m1_readdatavalid_o ? rd_data : '0;

`ifdef ARB_BOUNDS_CHECK_EN
    logic err_oob_q;
    always_ff @(posedge clk_i) begin
        if (reset_i)               err_oob_q <= 1'b0;
        else if (gnt_any && oob)   err_oob_q <= 1'b1;
    end
    assign err_oob_o = err_oob_q;
`else
    assign err_oob_o = 1'b0;
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: vector table, directed corner cases, and a randomized run
// against a rule-level arbitration/memory model.
module tb_onchip_mem_arbiter;
    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0, reset;
    logic [15:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken, err_oob;
    logic [31:0] mem_writedata, mem_readdata;

    int n_cmp = 0, n_bad = 0;

    onchip_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(51200), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i(clk), .reset_i(reset),
        .m0_address_i(m0_address), .m0_byteenable_i(m0_byteenable), .m0_read_i(m0_read),
        .m0_write_i(m0_write), .m0_writedata_i(m0_writedata), .m0_waitrequest_o(m0_waitrequest),
        .m0_readdata_o(m0_readdata), .m0_readdatavalid_o(m0_readdatavalid),
        .m1_address_i(m1_address), .m1_byteenable_i(m1_byteenable), .m1_read_i(m1_read),
        .m1_write_i(m1_write), .m1_writedata_i(m1_writedata), .m1_waitrequest_o(m1_waitrequest),
        .m1_readdata_o(m1_readdata), .m1_readdatavalid_o(m1_readdatavalid),
        .mem_address_o(mem_address), .mem_byteenable_o(mem_byteenable),
        .mem_chipselect_o(mem_chipselect), .mem_write_o(mem_write),
        .mem_writedata_o(mem_writedata), .mem_clken_o(mem_clken),
        .mem_readdata_i(mem_readdata), .err_oob_o(err_oob)
    );

    always #5 clk = ~clk;

    // RAM stand-in: address captured on select, unregistered q the following cycle.
    logic [31:0] ram [0:65535];
    logic [15:0] ram_addr_q = '0;
    always @(posedge clk) begin
        if (mem_chipselect) begin
            ram_addr_q <= mem_address;
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit r0, input bit w0, input logic [15:0] a0, input logic [3:0] be0,
                       input logic [31:0] d0, input bit r1, input bit w1, input logic [15:0] a1,
                       input logic [3:0] be1, input logic [31:0] d1);
        m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    endtask

    task automatic idle();
        drv(0, 0, 16'h0, 4'h0, 32'h0, 0, 0, 16'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Rule-level reference: who got the RAM last, how many grants in a row, and whether last cycle granted.
    int  last_m, streak;
    bit  prev_gnt;
    logic [31:0] ref_mem [0:65535];

    function automatic int arb(input bit q0, input bit q1);
        if (!q0 && !q1) return -1;
        if (q0 != q1)   return q0 ? 0 : 1;
        if (!prev_gnt)  return 1 - last_m;
        return (streak < MAX_HOLD) ? last_m : 1 - last_m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    typedef struct { bit q0; bit q1; int gnt; } vec_t;
    vec_t vt[16];

    initial begin
        for (int i = 0; i < 65536; i++) begin ram[i] = '0; ref_mem[i] = '0; end
        // From reset: m0 first tie, MAX_HOLD=4 rotation, switching and idle ties.
        vt[0]  = '{1,1,0};  vt[1]  = '{1,1,0};  vt[2]  = '{1,1,0};  vt[3]  = '{1,1,0};
        vt[4]  = '{1,1,1};  vt[5]  = '{1,0,0};  vt[6]  = '{0,0,-1}; vt[7]  = '{1,1,1};
        vt[8]  = '{0,1,1};  vt[9]  = '{0,1,1};  vt[10] = '{1,1,1};  vt[11] = '{1,1,0};
        vt[12] = '{0,0,-1}; vt[13] = '{1,1,1};  vt[14] = '{0,0,-1}; vt[15] = '{1,1,0};

        reset = 1'b1;
        idle();
        tick();
        @(negedge clk);
        chk("rst_wait0", 32'(m0_waitrequest), 1);
        chk("rst_wait1", 32'(m1_waitrequest), 1);
        chk("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
        chk("rst_cs", 32'({mem_chipselect, mem_write}), 0);
        chk("rst_clken", 32'(mem_clken), 1);
        chk("rst_err", 32'(err_oob), 0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drv(vt[i].q0, 0, 16'h20, 4'h0, 32'h0, vt[i].q1, 0, 16'h30, 4'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("vec%0d_wait0", i), 32'(m0_waitrequest), 32'(vt[i].gnt != 0));
            chk($sformatf("vec%0d_wait1", i), 32'(m1_waitrequest), 32'(vt[i].gnt != 1));
            chk($sformatf("vec%0d_cs", i), 32'(mem_chipselect), 32'(vt[i].gnt >= 0));
            tick();
        end

        // Single master write then read-back.
        do_reset();
        drv(0, 1, 16'h0010, 4'hF, 32'hA5A5_0001, 0, 0, 16'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("sm_wr_wait0", 32'(m0_waitrequest), 0);
        chk("sm_wr_memwr", 32'({mem_chipselect, mem_write}), 32'b11);
        tick();
        drv(1, 0, 16'h0010, 4'h0, 32'h0, 0, 0, 16'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("sm_rd_wait0", 32'(m0_waitrequest), 0);
        chk("sm_rd_be", 32'({mem_write, mem_byteenable}), 32'h0F);
        tick();
        idle();
        @(negedge clk);
        chk("sm_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'b10);
        chk("sm_data", m0_readdata, 32'hA5A5_0001);
        tick();

        // Byte lanes.
        drv(0, 1, 16'd5, 4'hF, 32'h1122_3344, 0, 0, 16'h0, 4'h0, 32'h0);
        tick();
        drv(0, 1, 16'd5, 4'b0100, 32'hFFFF_FFFF, 0, 0, 16'h0, 4'h0, 32'h0);
        tick();
        drv(1, 0, 16'd5, 4'h0, 32'h0, 0, 0, 16'h0, 4'h0, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("be_data", m0_readdata, 32'h11FF_3344);
        tick();

        // Contended read streams: m0 reads 0x10, m1 reads 5; then tie after idle with m1 last.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drv(1, 0, 16'h0010, 4'h0, 32'h0, 1, 0, 16'd5, 4'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("cont%0d_cs", i), 32'(mem_chipselect), 1);
            chk($sformatf("cont%0d_wait0", i), 32'(m0_waitrequest), 32'(i >= 4));
            if (i > 0) begin
                if (i - 1 < 4) chk($sformatf("cont%0d_d0", i), m0_readdata, 32'hA5A5_0001);
                else           chk($sformatf("cont%0d_d1", i), m1_readdata, 32'h11FF_3344);
                chk($sformatf("cont%0d_rdv", i), 32'({m0_readdatavalid, m1_readdatavalid}),
                    (i - 1 < 4) ? 32'b10 : 32'b01);
            end
            tick();
        end
        idle();
        tick();
        drv(1, 0, 16'h0010, 4'h0, 32'h0, 1, 0, 16'd5, 4'h0, 32'h0);
        @(negedge clk);
        chk("tie_wait0", 32'(m0_waitrequest), 0);
        chk("tie_wait1", 32'(m1_waitrequest), 1);
        tick();

        // Reset in the response cycle of an m1 read.
        do_reset();
        drv(0, 0, 16'h0, 4'h0, 32'h0, 1, 0, 16'd5, 4'h0, 32'h0);
        tick();
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("rstrd_rdv1", 32'(m1_readdatavalid), 0);
        tick();
        reset = 1'b0;
        drv(1, 0, 16'h0010, 4'h0, 32'h0, 1, 0, 16'd5, 4'h0, 32'h0);
        @(negedge clk);
        chk("rstrd_wait0", 32'(m0_waitrequest), 0);
        chk("rstrd_wait1", 32'(m1_waitrequest), 1);
        tick();

        // Read beyond MEM_DEPTH.
        do_reset();
        drv(1, 0, 16'd51200, 4'h0, 32'h0, 0, 0, 16'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("oob_wait0", 32'(m0_waitrequest), 0);
`ifdef ARB_BOUNDS_CHECK_EN
        chk("oob_cs", 32'(mem_chipselect), 0);
`else
        chk("oob_cs", 32'(mem_chipselect), 1);
`endif
        tick();
        idle();
        @(negedge clk);
        chk("oob_rdv", 32'(m0_readdatavalid), 1);
        chk("oob_data", m0_readdata, 32'h0);
        tick();
        @(negedge clk);
`ifdef ARB_BOUNDS_CHECK_EN
        chk("oob_err", 32'(err_oob), 1);
`else
        chk("oob_err", 32'(err_oob), 0);
`endif
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        last_m = 1; streak = 0; prev_gnt = 1'b0;
        begin
            bit pend = 1'b0;
            int pm = 0;
            logic [31:0] pdata = '0;
            for (int c = 0; c < 3000; c++) begin
                int g;
                bit wg;
                logic [15:0] ag;
                logic [3:0]  beg;
                logic [31:0] dg;
                drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 16'h100 + 16'($urandom_range(0, 7)),
                    4'($urandom), $urandom,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 16'h100 + 16'($urandom_range(0, 7)),
                    4'($urandom), $urandom);
                @(negedge clk);
                g   = arb(m0_read | m0_write, m1_read | m1_write);
                wg  = (g == 1) ? m1_write : m0_write;
                ag  = (g == 1) ? m1_address : m0_address;
                beg = (g == 1) ? m1_byteenable : m0_byteenable;
                dg  = (g == 1) ? m1_writedata : m0_writedata;
                chk("rnd_wait0", 32'(m0_waitrequest), 32'(g != 0));
                chk("rnd_wait1", 32'(m1_waitrequest), 32'(g != 1));
                chk("rnd_cs", 32'(mem_chipselect), 32'(g >= 0));
                chk("rnd_memwr", 32'(mem_write), 32'(g >= 0 && wg));
                if (g >= 0) chk("rnd_addr", 32'(mem_address), 32'(ag));
                chk("rnd_rdv0", 32'(m0_readdatavalid), 32'(pend && pm == 0));
                chk("rnd_rdv1", 32'(m1_readdatavalid), 32'(pend && pm == 1));
                chk("rnd_rd0", m0_readdata, (pend && pm == 0) ? pdata : 32'h0);
                chk("rnd_rd1", m1_readdata, (pend && pm == 1) ? pdata : 32'h0);
                @(posedge clk);
                pend = (g >= 0) && !wg;
                pm   = g;
                if (g >= 0) begin
                    if (wg) ref_mem[ag] = merge(ref_mem[ag], dg, beg);
                    else    pdata = ref_mem[ag];
                    streak   = (prev_gnt && g == last_m) ? streak + 1 : 1;
                    last_m   = g;
                    prev_gnt = 1'b1;
                end else begin
                    prev_gnt = 1'b0;
                end
                #1;
            end
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
